// File: rtl/displayer.sv
// Registered glyph-code to 7-segment decoder for one digit of the 12-hour clock.
// Segment order is {g,f,e,d,c,b,a}; ACTIVE_LOW inverts the whole word for common-anode parts.
module displayer #(
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] disp
);

  // XOR mask applied after blanking, so a dark digit is dark in either polarity.
  localparam logic [6:0] POL_MASK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0] seg;
  logic [6:0] disp_q = POL_MASK;

  always_comb begin
    seg = 7'h00;
    unique case (code)
      4'd0:  seg = 7'h3F;
      4'd1:  seg = 7'h06;
      4'd2:  seg = 7'h5B;
      4'd3:  seg = 7'h4F;
      4'd4:  seg = 7'h66;
      4'd5:  seg = 7'h6D;
      4'd6:  seg = 7'h7D;
      4'd7:  seg = 7'h07;
      4'd8:  seg = 7'h7F;
      4'd9:  seg = 7'h6F;
      4'd10: seg = 7'h37;
      4'd11: seg = 7'h76;
      4'd12: seg = 7'h77;
      4'd13: seg = 7'h73;
      4'd14: seg = 7'h40;
      4'd15: seg = 7'h00;
      default: seg = 7'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || blank) begin
      disp_q <= POL_MASK;
    end else begin
      disp_q <= seg ^ POL_MASK;
    end
  end

  assign disp = disp_q;

endmodule

// File: tb/tb_displayer.sv
// Bench for displayer: directed plan steps then random traffic, both polarities side by side,
// checked against a glyph model built from segment-letter descriptions.
module tb_displayer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       blank = 1'b0;
  logic [3:0] code = 4'd0;
  logic [6:0] disp_hi;
  logic [6:0] disp_lo;

  always #5 clk = ~clk;

  displayer #(.ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .reset(reset), .code(code), .blank(blank), .disp(disp_hi)
  );

  displayer #(.ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .reset(reset), .code(code), .blank(blank), .disp(disp_lo)
  );

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // Lit segments of each glyph, by letter name.
  string glyph_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcef", "bcefg", "abcefg", "abefg", "g", ""
  };

  function automatic logic [6:0] glyph_mask(input int c);
    logic [6:0] m;
    string s;
    m = 7'h00;
    s = glyph_segs[c];
    for (int i = 0; i < s.len(); i++) m[s[i] - "a"] = 1'b1;
    return m;
  endfunction

  // Returns {expected active-high, expected active-low} for one sampled input set.
  function automatic logic [13:0] model(input logic [3:0] c, input logic b, input logic r);
    logic [6:0] lit;
    lit = (r || b) ? 7'h00 : glyph_mask(int'(c));
    return {lit, ~lit};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic b, input logic r, input string tag);
    logic [13:0] e;
    @(negedge clk);
    code  = c;
    blank = b;
    reset = r;
    exp_q.push_back(model(c, b, r));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_hi"}, disp_hi, e[13:7]);
    check({tag, "_lo"}, disp_lo, e[6:0]);
  endtask

  initial begin
    // Reset held two cycles with code 8, then release.
    step(4'd8, 1'b0, 1'b1, "reset0");
    step(4'd8, 1'b0, 1'b1, "reset1");
    check("reset_lit_hi", disp_hi, 7'h00);
    check("reset_lit_lo", disp_lo, 7'h7F);
    step(4'd8, 1'b0, 1'b0, "release");
    check("release_lit_hi", disp_hi, 7'h7F);

    for (int i = 0; i < 10; i++) step(4'(i), 1'b0, 1'b0, "digit");

    step(4'd12, 1'b0, 1'b0, "glyph_a");
    check("glyph_a_lit", disp_hi, 7'h77);
    step(4'd13, 1'b0, 1'b0, "glyph_p");
    step(4'd10, 1'b0, 1'b0, "glyph_m");
    step(4'd11, 1'b0, 1'b0, "glyph_h");
    step(4'd14, 1'b0, 1'b0, "glyph_dash");
    step(4'd15, 1'b0, 1'b0, "glyph_blank");

    // Blank pulse, then a code change hidden under the blank cycle.
    step(4'd8, 1'b0, 1'b0, "blank_pre");
    step(4'd8, 1'b1, 1'b0, "blank_on");
    step(4'd8, 1'b0, 1'b0, "blank_post");
    step(4'd3, 1'b1, 1'b0, "blank_chg");
    step(4'd3, 1'b0, 1'b0, "blank_chg_post");
    check("blank_chg_lit", disp_hi, 7'h4F);

    step(4'd1, 1'b0, 1'b0, "pol_one");
    check("pol_one_lit", disp_lo, 7'h79);

    // Mid-stream reset pulse while toggling 5/6.
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'd5 : 4'd6, 1'b0, (i == 4), "midreset");

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
